// File: rtl/tsv_test_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// tst_pkg -- shared types and constants for the TSV layer self-test controller.
//   state_t     : controller states
//   *_DEF       : default TIMEOUT / SYNC_WORD / DONE_WORD parameter values
//   make_token  : builds a {13'b0, chip_id, word} bus token
// ---------------------------------------------------------------------------
package tst_pkg;

   localparam int DATA_W  = 32;
   localparam int STEP_W  = 4;
   localparam int TIMER_W = 8;
   localparam int ERR_W   = 4;
   localparam int ID_W    = 3;

   localparam int          TIMEOUT_DEF   = 16;
   localparam logic [15:0] SYNC_WORD_DEF = 16'hBEAF;
   localparam logic [15:0] DONE_WORD_DEF = 16'hDEAD;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RX_SYNC,
      ST_TX_PAT,
      ST_WAIT_ECHO,
      ST_TX_SYNC,
      ST_RX_DONE,
      ST_STANDBY
   } state_t;

   function automatic logic [DATA_W-1:0] make_token(input logic [ID_W-1:0] id,
                                                    input logic [15:0]     word);
      return {13'b0, id, word};
   endfunction

endpackage

// File: rtl/tsv_test_ctrl_if.sv
// ---------------------------------------------------------------------------
// tsv_test_ctrl_if -- control/status and inter-layer bus of the self-test
// controller.
//   start, f_layer, l_layer, data_in        : driven by the environment
//   data_out, chip_id, busy, done, pass,
//   err_cnt                                  : driven by the controller
// Modports: master = environment side, slave = controller side.
// ---------------------------------------------------------------------------
interface tsv_test_ctrl_if;
   import tst_pkg::*;

   logic              start;
   logic              f_layer;
   logic              l_layer;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic [ID_W-1:0]   chip_id;
   logic              busy;
   logic              done;
   logic              pass;
   logic [ERR_W-1:0]  err_cnt;

   modport master (
      output start, f_layer, l_layer, data_in,
      input  data_out, chip_id, busy, done, pass, err_cnt
   );

   modport slave (
      input  start, f_layer, l_layer, data_in,
      output data_out, chip_id, busy, done, pass, err_cnt
   );

endinterface

// File: rtl/tsv_test_ctrl_pat_gen.sv
// ---------------------------------------------------------------------------
// tst_pat_gen -- combinational test-pattern generator.
//   step    in  4   current step k (1..15)
//   pattern out 32  k replicated into every nibble
//   echo    out 32  expected reply: upper half kept, lower half inverted
// Since k is never 0 the upper half of echo is never 0, so an idle bus can
// never be mistaken for an echo.
// ---------------------------------------------------------------------------
module tst_pat_gen
   import tst_pkg::*;
(
   input  logic [STEP_W-1:0] step,
   output logic [DATA_W-1:0] pattern,
   output logic [DATA_W-1:0] echo
);

   genvar gi;
   generate
      for (gi = 0; gi < DATA_W / STEP_W; gi++) begin : g_nibble
         assign pattern[gi*STEP_W +: STEP_W] = step;
      end
   endgenerate

   assign echo = {pattern[DATA_W-1:DATA_W/2], ~pattern[DATA_W/2-1:0]};

endmodule

// File: rtl/tsv_test_ctrl.sv
// ---------------------------------------------------------------------------
// tsv_test_ctrl -- per-layer TSV self-test controller.
// The bottom layer starts numbering at 0; upper layers take their id from the
// sync token of the layer below. Each layer sends 15 patterns and waits for
// their echoes, counting steps that time out. Non-top layers then pass a sync
// token upward and wait for the done token coming back down.
//   clk   in   sole clock, rising edge
//   rst   in   synchronous active-high reset
//   bus   slave modport of tsv_test_ctrl_if (start, layer flags, data bus,
//         chip_id, busy/done/pass status, err_cnt)
// ---------------------------------------------------------------------------
module tsv_test_ctrl
   import tst_pkg::*;
#(
   parameter int          TIMEOUT   = TIMEOUT_DEF,
   parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF,
   parameter logic [15:0] DONE_WORD = DONE_WORD_DEF
)(
   input  logic           clk,
   input  logic           rst,
   tsv_test_ctrl_if.slave bus
);

   state_t             state_reg,    state_next;
   logic [STEP_W-1:0]  step_reg,     step_next;
   logic [TIMER_W-1:0] timer_reg,    timer_next;
   logic [ID_W-1:0]    chip_id_reg,  chip_id_next;
   logic [ERR_W-1:0]   err_reg,      err_next;
   logic [DATA_W-1:0]  data_out_reg, data_out_next;

   logic [DATA_W-1:0]  pattern;
   logic [DATA_W-1:0]  echo;
   logic               match;
   logic               expired;

   tst_pat_gen u_pat_gen (
      .step    (step_reg),
      .pattern (pattern),
      .echo    (echo)
   );

   assign match   = (bus.data_in == echo);
   assign expired = (timer_reg == TIMER_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         step_reg     <= STEP_W'(1);
         timer_reg    <= '0;
         chip_id_reg  <= '0;
         err_reg      <= '0;
         data_out_reg <= '0;
      end else begin
         state_reg    <= state_next;
         step_reg     <= step_next;
         timer_reg    <= timer_next;
         chip_id_reg  <= chip_id_next;
         err_reg      <= err_next;
         data_out_reg <= data_out_next;
      end
   end

   // data_out is registered: the value chosen here appears during the
   // cycle after the current state, so the done token is loaded on the
   // transition into STANDBY and shows on its first cycle.
   always_comb begin
      state_next    = state_reg;
      step_next     = step_reg;
      timer_next    = timer_reg;
      chip_id_next  = chip_id_reg;
      err_next      = err_reg;
      data_out_next = '0;

      case (state_reg)
         ST_IDLE, ST_STANDBY: begin
            if (bus.start) begin
               err_next = '0;
               if (bus.f_layer) begin
                  chip_id_next = '0;
                  step_next    = STEP_W'(1);
                  state_next   = ST_TX_PAT;
               end else begin
                  state_next   = ST_RX_SYNC;
               end
            end
         end

         ST_RX_SYNC: begin
            if (bus.data_in[15:0] == SYNC_WORD) begin
               chip_id_next = bus.data_in[18:16] + 3'd1;   // 7 wraps to 0
               step_next    = STEP_W'(1);
               state_next   = ST_TX_PAT;
            end
         end

         ST_TX_PAT: begin
            data_out_next = pattern;
            timer_next    = '0;
            state_next    = ST_WAIT_ECHO;
         end

         ST_WAIT_ECHO: begin
            timer_next = timer_reg + TIMER_W'(1);
            if (match || expired) begin
               if (!match && (err_reg != '1))
                  err_next = err_reg + ERR_W'(1);
               if (step_reg != '1) begin
                  step_next  = step_reg + STEP_W'(1);
                  state_next = ST_TX_PAT;
               end else if (bus.l_layer) begin
                  data_out_next = make_token(chip_id_reg, DONE_WORD);
                  state_next    = ST_STANDBY;
               end else begin
                  state_next    = ST_TX_SYNC;
               end
            end
         end

         ST_TX_SYNC: begin
            data_out_next = make_token(chip_id_reg, SYNC_WORD);
            state_next    = ST_RX_DONE;
         end

         ST_RX_DONE: begin
            if (bus.data_in[15:0] == DONE_WORD) begin
               data_out_next = make_token(chip_id_reg, DONE_WORD);
               state_next    = ST_STANDBY;
            end
         end

         default: state_next = ST_IDLE;
      endcase
   end

   assign bus.data_out = data_out_reg;
   assign bus.chip_id  = chip_id_reg;
   assign bus.err_cnt  = err_reg;
   assign bus.busy     = (state_reg != ST_IDLE) && (state_reg != ST_STANDBY);
   assign bus.done     = (state_reg == ST_STANDBY);
   assign bus.pass     = (state_reg == ST_STANDBY) && (err_reg == '0);

endmodule
